// File: rtl/activity_indicator_if.sv
// activity_indicator_if
//   Board-side signal bundle for activity_indicator.
//   activity    : per-channel activity pulses (synchronous to clk)
//   blink_en    : per-channel mode, 0 = stretch, 1 = blink
//   btn_n       : raw active-low reset button (asynchronous)
//   led         : per-channel indicator outputs
//   window_tick : one-cycle pulse after every window boundary
//   rst_req     : fixed-width reset request for the SoC
//   master = board/stimulus side, slave = activity_indicator.
`timescale 1ns/1ps
interface activity_indicator_if #(
    parameter int NUM_CH = 4
) ();
    logic [NUM_CH-1:0] activity;
    logic [NUM_CH-1:0] blink_en;
    logic              btn_n;
    logic [NUM_CH-1:0] led;
    logic              window_tick;
    logic              rst_req;

    modport master (
        output activity,
        output blink_en,
        output btn_n,
        input  led,
        input  window_tick,
        input  rst_req
    );

    modport slave (
        input  activity,
        input  blink_en,
        input  btn_n,
        output led,
        output window_tick,
        output rst_req
    );
endinterface

// File: rtl/activity_indicator.sv
// activity_indicator
//   Stretches short activity pulses into LED windows of 2^WINDOW_BITS cycles
//   (per-channel stretch or blink), and turns a debounced press of the board
//   reset button into a RST_PULSE_CYCLES-wide reset request.
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : activity_indicator_if.slave (activity, blink_en, btn_n in;
//             led, window_tick, rst_req out, all outputs straight from flops)
`timescale 1ns/1ps
module activity_indicator #(
    parameter int NUM_CH           = 4,
    parameter int WINDOW_BITS      = 20,
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int RST_PULSE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    activity_indicator_if.slave   bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PULSE_W = $clog2(RST_PULSE_CYCLES + 1);

    localparam logic [WINDOW_BITS-1:0] WIN_ZERO   = {WINDOW_BITS{1'b0}};
    localparam logic [WINDOW_BITS-1:0] WIN_ONE    = {{(WINDOW_BITS-1){1'b0}}, 1'b1};
    localparam logic [WINDOW_BITS-1:0] WIN_ONES   = {WINDOW_BITS{1'b1}};
    localparam logic [DB_W-1:0]        DB_ZERO    = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]        DB_ONE     = {{(DB_W-1){1'b0}}, 1'b1};
    // Firing on the last mismatch count makes btn_db change exactly
    // DEBOUNCE_CYCLES edges after btn_s changes.
    localparam logic [DB_W-1:0]        DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PULSE_W-1:0]     PULSE_ZERO = {PULSE_W{1'b0}};
    localparam logic [PULSE_W-1:0]     PULSE_ONE  = {{(PULSE_W-1){1'b0}}, 1'b1};
    localparam logic [PULSE_W-1:0]     PULSE_LOAD = PULSE_W'(RST_PULSE_CYCLES);

    logic [WINDOW_BITS-1:0] window_cnt_r;
    logic [NUM_CH-1:0]      seen_r;
    logic [NUM_CH-1:0]      led_r;
    logic                   window_tick_r;
    logic                   boundary_s;
    logic [NUM_CH-1:0]      hit_s;
    logic [NUM_CH-1:0]      led_nxt_s;

    logic                   btn_meta_r;
    logic                   btn_sync_r;
    logic                   btn_s;
    logic                   btn_db_r;
    logic [DB_W-1:0]        db_cnt_r;
    logic                   db_mismatch_s;
    logic                   db_fire_s;
    logic                   press_s;
    logic                   press_r;
    logic [PULSE_W-1:0]     pulse_cnt_r;
    logic [PULSE_W-1:0]     pulse_nxt_s;
    logic                   rst_req_r;

    assign bus.led         = led_r;
    assign bus.window_tick = window_tick_r;
    assign bus.rst_req     = rst_req_r;
    assign btn_s           = btn_sync_r;

    // Boundary detect and next LED value per channel.
    always_comb begin
        boundary_s = (window_cnt_r == WIN_ZERO);
        hit_s      = seen_r | bus.activity;
        // Stretch: led = hit. Blink: led = hit ? ~led : 0.
        led_nxt_s  = hit_s & ~(bus.blink_en & led_r);
    end

    // Free-running down-counter; wraps from 0 back to all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_cnt_r <= WIN_ONES;
        end else begin
            window_cnt_r <= window_cnt_r - WIN_ONE;
        end
    end

    // Seen flags, LED update and window tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_r        <= {NUM_CH{1'b0}};
            led_r         <= {NUM_CH{1'b0}};
            window_tick_r <= 1'b0;
        end else begin
            window_tick_r <= boundary_s;
            if (boundary_s) begin
                // Activity in the boundary cycle is already folded into hit_s.
                seen_r <= {NUM_CH{1'b0}};
                led_r  <= led_nxt_s;
            end else begin
                seen_r <= seen_r | bus.activity;
                led_r  <= led_r;
            end
        end
    end

    // Two-flop synchroniser for the raw button, idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_r <= 1'b1;
            btn_sync_r <= 1'b1;
        end else begin
            btn_meta_r <= bus.btn_n;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Debounce decision and press detection.
    always_comb begin
        db_mismatch_s = (btn_s != btn_db_r);
        db_fire_s     = db_mismatch_s && (db_cnt_r == DB_LAST);
        press_s       = db_fire_s && !btn_s;
    end

    // Debounce counter and debounced button state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r <= DB_ZERO;
            btn_db_r <= 1'b1;
            press_r  <= 1'b0;
        end else begin
            press_r <= press_s;
            if (!db_mismatch_s) begin
                db_cnt_r <= DB_ZERO;
                btn_db_r <= btn_db_r;
            end else if (db_fire_s) begin
                db_cnt_r <= DB_ZERO;
                btn_db_r <= btn_s;
            end else begin
                db_cnt_r <= db_cnt_r + DB_ONE;
                btn_db_r <= btn_db_r;
            end
        end
    end

    // Next pulse count: load on a press (also reloads an active pulse).
    always_comb begin
        if (press_r) begin
            pulse_nxt_s = PULSE_LOAD;
        end else if (pulse_cnt_r != PULSE_ZERO) begin
            pulse_nxt_s = pulse_cnt_r - PULSE_ONE;
        end else begin
            pulse_nxt_s = PULSE_ZERO;
        end
    end

    // Pulse counter; rst_req registered from the next count so it is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt_r <= PULSE_ZERO;
            rst_req_r   <= 1'b0;
        end else begin
            pulse_cnt_r <= pulse_nxt_s;
            rst_req_r   <= (pulse_nxt_s != PULSE_ZERO);
        end
    end

endmodule
